// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-issue decode/execute/writeback sequencer for the registered ALU
`timescale 1ns/1ps
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_func,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] alu_a_q, alu_b_q;
  logic [5:0]  alu_func_q;
  logic [4:0]  dest_q;
  logic        illegal_q;
  logic [31:0] rf_q [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val;
  logic        legal, accept;
  logic [31:0] dec_a, dec_b;
  logic [5:0]  dec_func;
  logic [4:0]  dec_dest;

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // r0 is hardwired to zero on every read port
  assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

  always_comb begin
    legal    = 1'b0;
    dec_a    = '0;
    dec_b    = '0;
    dec_func = '0;
    dec_dest = '0;
    if (op == 6'd0) begin
      case (funct)
        6'd32, 6'd34, 6'd36, 6'd37, 6'd43: begin
          legal    = 1'b1;
          dec_a    = rs_val;
          dec_b    = rt_val;
          dec_func = funct;
          dec_dest = rd;
        end
        6'd0: begin
          legal    = 1'b1;
          dec_a    = {27'd0, shamt};
          dec_b    = rt_val;
          dec_func = 6'd0;
          dec_dest = rd;
        end
        6'd4: begin
          legal    = 1'b1;
          dec_a    = {27'd0, rs_val[4:0]};
          dec_b    = rt_val;
          dec_func = 6'd4;
          dec_dest = rd;
        end
        default: legal = 1'b0;
      endcase
    end else if (op == 6'd8) begin
      legal    = 1'b1;
      dec_a    = rs_val;
      dec_b    = {{16{imm[15]}}, imm};
      dec_func = 6'd8;
      dec_dest = rt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = ~rst;
        accept      = instr_valid & ~rst;
        if (accept && legal) state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Illegal accepts only pulse the flag; operands keep their previous values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
      dest_q     <= '0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= accept & ~legal;
      if (accept && legal) begin
        alu_a_q    <= dec_a;
        alu_b_q    <= dec_b;
        alu_func_q <= dec_func;
        dest_q     <= dec_dest;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (state_q == S_WB && dest_q != 5'd0) begin
      rf_q[dest_q] <= alu_result;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_func = alu_func_q;
  assign illegal  = illegal_q;
  assign wb_valid = (state_q == S_WB);
  assign wb_addr  = dest_q;
  assign wb_data  = alu_result;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue with a registered ALU model
`timescale 1ns/1ps
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_func;
  logic [31:0] alu_result = '0;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int prev_acc = 0;

  alu_issue dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(alu_result), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(logic [31:0] a, logic [31:0] b, logic [5:0] f);
    case (f)
      6'd0, 6'd4:  return b << a[4:0];
      6'd8, 6'd32: return a + b;
      6'd34:       return a - b;
      6'd36:       return a & b;
      6'd37:       return a | b;
      6'd43:       return ~(a | b);
      default:     return 32'd0;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_model(alu_a, alu_b, alu_func);
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      prev_acc = last_acc;
      last_acc = cyc;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic read_reg(string tag, logic [4:0] a, logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic issue(logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && !instr_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!instr_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic run_op(string tag, logic [31:0] w, logic [31:0] ea, logic [31:0] eb,
                        logic [5:0] ef, logic [4:0] ed, logic [31:0] ev);
    issue(w);
    check({tag, ".alu_a"}, alu_a, ea);
    check({tag, ".alu_b"}, alu_b, eb);
    check({tag, ".alu_func"}, {26'd0, alu_func}, {26'd0, ef});
    check({tag, ".ready_exec"}, {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
    check({tag, ".wb_addr"}, {27'd0, wb_addr}, {27'd0, ed});
    check({tag, ".wb_data"}, wb_data, ev);
    @(posedge clk); #1;
    check({tag, ".wb_done"}, {31'd0, wb_valid}, 32'd0);
    check({tag, ".ready_back"}, {31'd0, instr_ready}, 32'd1);
    read_reg({tag, ".rf"}, ed, (ed == 5'd0) ? 32'd0 : ev);
  endtask

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; dbg_addr = '0;
    #1;
    check("rst.ready_held", {31'd0, instr_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst.ready", {31'd0, instr_ready}, 32'd1);
    check("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst.alu_func", {26'd0, alu_func}, 32'd0);
    check("rst.alu_a", alu_a, 32'd0);
    check("rst.illegal", {31'd0, illegal}, 32'd0);
    for (int i = 0; i < 32; i++) read_reg($sformatf("rst.r%0d", i), i[4:0], 32'd0);

    run_op("addi_r1", 32'h20010005, 32'd0, 32'd5, 6'd8, 5'd1, 32'd5);
    run_op("addi_r2", 32'h2002FFFD, 32'd0, 32'hFFFFFFFD, 6'd8, 5'd2, 32'hFFFFFFFD);

    // add then sub with instr_valid held high throughout
    instr = 32'h00221820; instr_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b.add_func", {26'd0, alu_func}, 32'd32);
    check("b2b.add_a", alu_a, 32'd5);
    check("b2b.add_b", alu_b, 32'hFFFFFFFD);
    instr = 32'h00412822;
    @(posedge clk); #1;
    check("b2b.ready_wb", {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    read_reg("b2b.r3", 5'd3, 32'd2);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("b2b.sub_func", {26'd0, alu_func}, 32'd34);
    check("b2b.sub_a", alu_a, 32'hFFFFFFFD);
    check("b2b.sub_b", alu_b, 32'd5);
    check("b2b.gap", last_acc - prev_acc, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    read_reg("b2b.r5", 5'd5, 32'hFFFFFFF8);

    run_op("sll_r4", 32'h00012100, 32'd4, 32'd5, 6'd0, 5'd4, 32'h50);
    run_op("addi_r7", 32'h20070024, 32'd0, 32'h24, 6'd8, 5'd7, 32'h24);
    run_op("sllv_r8", 32'h00E14004, 32'd4, 32'd5, 6'd4, 5'd8, 32'h50);
    run_op("and_r9", 32'h00224824, 32'd5, 32'hFFFFFFFD, 6'd36, 5'd9, 32'd5);
    run_op("or_r11", 32'h00225825, 32'd5, 32'hFFFFFFFD, 6'd37, 5'd11, 32'hFFFFFFFD);
    run_op("nor_r10", 32'h0022502B, 32'd5, 32'hFFFFFFFD, 6'd43, 5'd10, 32'd2);

    // lw then slt back-to-back: both dropped, flag pulses per accept
    instr = 32'h8C010000; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 32'h0000002A;
    check("ill.lw_pulse", {31'd0, illegal}, 32'd1);
    check("ill.lw_ready", {31'd0, instr_ready}, 32'd1);
    check("ill.lw_wb", {31'd0, wb_valid}, 32'd0);
    check("ill.alu_func_kept", {26'd0, alu_func}, 32'd43);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("ill.slt_pulse", {31'd0, illegal}, 32'd1);
    check("ill.alu_a_kept", alu_a, 32'd5);
    @(posedge clk); #1;
    check("ill.pulse_end", {31'd0, illegal}, 32'd0);
    check("ill.no_wb", {31'd0, wb_valid}, 32'd0);

    run_op("addi_r0", 32'h20000007, 32'd0, 32'd7, 6'd8, 5'd0, 32'd7);

    issue(32'h20060009);
    rst = 1'b1;
    #1;
    check("midrst.ready", {31'd0, instr_ready}, 32'd0);
    check("midrst.alu_b", alu_b, 32'd0);
    check("midrst.alu_func", {26'd0, alu_func}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst.ready_after", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("midrst.no_wb%0d", i), {31'd0, wb_valid}, 32'd0);
    end
    read_reg("midrst.r6", 5'd6, 32'd0);
    read_reg("midrst.r1", 5'd1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
